// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder built-in self-test: FSM state encoding
// and the sweep vector width helper.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    function automatic int vec_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/adder_bist_check.sv
// Golden model and comparator: flags when {Cout,S} differs from A+B+Cin.
module adder_bist_check
    import adder_bist_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [WIDTH-1:0] S,
    input  logic             Cout,
    output logic             mismatch
);

    logic [WIDTH:0] w_exp;

    assign w_exp    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign mismatch = ({Cout, S} != w_exp);

endmodule

// File: rtl/adder4bit_bist.sv
// Exhaustive self-test controller for a WIDTH-bit adder: sweeps every
// {Cin,B,A}, waits SETTLE cycles per vector and records mismatches.
module adder4bit_bist
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               Cin,
    input  logic [WIDTH-1:0]   S,
    input  logic               Cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic               fail_valid,
    output logic [2*WIDTH:0]   first_fail
);

    localparam int VW = vec_width(WIDTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 1);

    bist_state_e   r_state;
    bist_state_e   w_next;
    logic [VW-1:0] r_v;
    logic [CW-1:0] r_wait;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [VW:0]   r_err;
    logic          r_fail_valid;
    logic [VW-1:0] r_first_fail;

    logic          w_mismatch;
    logic          w_last;
    logic [VW:0]   w_err_next;

    // Operands come straight from vector register bits, so they never glitch.
    assign A   = r_v[WIDTH-1:0];
    assign B   = r_v[2*WIDTH-1:WIDTH];
    assign Cin = r_v[2*WIDTH];

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

    assign w_last     = &r_v;
    assign w_err_next = r_err + {{VW{1'b0}}, w_mismatch};

    adder_bist_check #(
        .WIDTH(WIDTH)
    ) u_check (
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .S       (S),
        .Cout    (Cout),
        .mismatch(w_mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SETTLE;
            ST_SETTLE: if (r_wait == WAIT_LAST) w_next = ST_CHECK;
            ST_CHECK:  w_next = w_last ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v          <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_v          <= '0;
                        r_wait       <= '0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_wait <= (r_wait == WAIT_LAST) ? '0 : r_wait + CW'(1);
                end
                ST_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_first_fail <= r_v;
                        r_fail_valid <= 1'b1;
                    end
                    // Verdict includes the final vector's result, hence w_err_next.
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_v <= r_v + VW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder4bit_bist.sv
// Scoreboard bench for adder4bit_bist: a behavioural adder with selectable
// faults feeds the controller; expected sweep results are queued per start.
module tb_adder4bit_bist;

    typedef struct {
        int   start_cyc;
        int   lat;
        logic pass;
        int   err;
        logic fv;
        int   ff;
    } exp_t;

    logic       clk;
    logic       rst;
    int         cyc;
    int         n_chk;
    int         n_pass;
    int         n_fail;
    int         mode;

    logic       start1, start3;
    logic [3:0] A1, B1, S1, A3, B3, S3;
    logic       Cin1, Cout1, Cin3, Cout3;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [9:0] err1, err3;
    logic [8:0] ff1, ff3;
    logic [4:0] sum1, sum3;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int   runs_checked;
    int   bad_runs;

    adder4bit_bist #(.WIDTH(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(A1), .B(B1), .Cin(Cin1), .S(S1), .Cout(Cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail(ff1)
    );

    adder4bit_bist #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .A(A3), .B(B3), .Cin(Cin3), .S(S3), .Cout(Cout3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail(ff3)
    );

    // Adder under test: mode 0 good, 1 Cout stuck-at-0, 2 S[0] inverted.
    assign sum1 = {1'b0, A1} + {1'b0, B1} + {4'b0, Cin1};
    always_comb begin
        S1    = sum1[3:0];
        Cout1 = sum1[4];
        if (mode == 1) Cout1 = 1'b0;
        if (mode == 2) S1[0] = ~sum1[0];
    end

    assign sum3 = {1'b0, A3} + {1'b0, B3} + {4'b0, Cin3};
    assign S3    = sum3[3:0];
    assign Cout3 = sum3[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) begin
            n_pass = n_pass + 1;
        end else begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : mon1
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done1) begin
                check("dut1_done_expected", int'(q1.size() != 0), 1);
                check("dut1_done_single_cycle", int'(prev_done), 0);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("dut1_latency", cyc - e1.start_cyc, e1.lat);
                    check("dut1_pass", int'(pass1), int'(e1.pass));
                    check("dut1_err_count", int'(err1), e1.err);
                    check("dut1_fail_valid", int'(fv1), int'(e1.fv));
                    check("dut1_first_fail", int'(ff1), e1.ff);
                    check("dut1_busy_at_done", int'(busy1), 0);
                end
            end
            prev_done = done1;
        end
    end

    initial begin : mon3
        logic [8:0] prev_vec;
        logic [8:0] cur;
        logic       have_ref;
        int         run_len;
        prev_vec = '0;
        have_ref = 1'b0;
        run_len  = 0;
        forever begin
            @(posedge clk);
            #1;
            cur = {Cin3, B3, A3};
            if (busy3) begin
                if (cur != prev_vec) begin
                    if (have_ref) begin
                        runs_checked = runs_checked + 1;
                        if (run_len != 4) bad_runs = bad_runs + 1;
                    end
                    have_ref = 1'b1;
                    run_len  = 1;
                end else begin
                    run_len = run_len + 1;
                end
            end
            prev_vec = cur;
            if (done3) begin
                check("dut3_done_expected", int'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    e3 = q3.pop_front();
                    check("dut3_latency", cyc - e3.start_cyc, e3.lat);
                    check("dut3_pass", int'(pass3), int'(e3.pass));
                    check("dut3_err_count", int'(err3), e3.err);
                    check("dut3_fail_valid", int'(fv3), int'(e3.fv));
                    check("dut3_busy_at_done", int'(busy3), 0);
                end
            end
        end
    end

    task automatic wait_empty1(input int budget);
        for (int i = 0; i < budget && q1.size() != 0; i++) @(posedge clk);
        #2;
        check("dut1_sweep_finished", q1.size(), 0);
    endtask

    task automatic sweep1(input int m, input logic p, input int err,
                          input logic fv, input int ff);
        @(negedge clk);
        mode = m;
        q1.push_back('{cyc, 1025, p, err, fv, ff});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_empty1(1200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        runs_checked = 0; bad_runs = 0;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy1), 0);
        check("reset_done", int'(done1), 0);
        check("reset_pass", int'(pass1), 0);
        check("reset_err_count", int'(err1), 0);
        check("reset_fail_valid", int'(fv1), 0);
        check("reset_first_fail", int'(ff1), 0);
        check("reset_vector", int'({Cin1, B1, A1}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Good adder, then the two fault models.
        sweep1(0, 1'b1, 0, 1'b0, 9'h000);
        @(negedge clk);
        check("idle_holds_last_vector", int'({Cin1, B1, A1}), 9'h1FF);
        check("idle_busy_low", int'(busy1), 0);
        check("idle_pass_held", int'(pass1), 1);
        sweep1(1, 1'b0, 256, 1'b1, 9'h01F);
        sweep1(2, 1'b0, 512, 1'b1, 9'h000);

        // A second start mid-sweep must not restart or add a done pulse.
        @(negedge clk);
        mode = 0;
        q1.push_back('{cyc, 1025, 1'b1, 0, 1'b0, 0});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (98) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_empty1(1200);
        repeat (20) @(negedge clk);

        // Abort at vector 0x80 with the Cout fault so result state is non-zero.
        mode = 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 600 && {Cin1, B1, A1} != 9'h080; i++) @(negedge clk);
        check("mid_sweep_vector", int'({Cin1, B1, A1}), 9'h080);
        check("mid_sweep_err_count", int'(err1), 28);
        check("mid_sweep_first_fail", int'(ff1), 9'h01F);
        check("mid_sweep_busy", int'(busy1), 1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy1), 0);
        check("abort_done", int'(done1), 0);
        check("abort_err_count", int'(err1), 0);
        check("abort_fail_valid", int'(fv1), 0);
        check("abort_first_fail", int'(ff1), 0);
        check("abort_vector", int'({Cin1, B1, A1}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", int'(done1), 0);
        sweep1(0, 1'b1, 0, 1'b0, 9'h000);

        // Longer settle: four cycles per vector, 2049 cycles to done.
        @(negedge clk);
        q3.push_back('{cyc, 2049, 1'b1, 0, 1'b0, 0});
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 2300 && q3.size() != 0; i++) @(posedge clk);
        #2;
        check("dut3_sweep_finished", q3.size(), 0);
        check("dut3_runs_observed", runs_checked, 510);
        check("dut3_unstable_runs", bad_runs, 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
